stump_controller: RTL

Sequencer for the STUMPS logic-BIST datapath. It drives the PRPG, the scan chains and the MISR through one complete self-test session: seed load, shift/capture loop, final unload and signature compare. The block sits between the test-access/top-level control and the PRPG, scan-chain and MISR instances. It issues `internalRst` and the enables that those instances consume.

---
 rtl/stump_controller.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/stump_controller.sv
// STUMPS logic-BIST session sequencer.
// Walks the PRPG / scan chains / MISR through seed load, the shift/capture
// loop, the final unload and the signature compare.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for start, every output low
// S_INIT    | one cycle: internalRst loads the PRPG and MISR seeds
// S_SHIFT   | scan load/unload, L cycles; MISR compacts after the first load
// S_CAPTURE | one functional capture cycle, pattern_idx advances
// S_COMPARE | one cycle: MISR_Sig is compared against Golden_Sig
// S_DONE    | done held high with pass, waiting for a restart
module stump_controller #(
    parameter int CL_W      = 16,
    parameter int PC_W      = 16,
    parameter int MISR_Size = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CL_W-1:0]      Chain_Length,
    input  logic [PC_W-1:0]      Pattern_Count,
    input  logic [MISR_Size-1:0] MISR_Sig,
    input  logic [MISR_Size-1:0] Golden_Sig,
    output logic                 internalRst,
    output logic                 PRPG_En,
    output logic                 MISR_En,
    output logic                 Scan_En,
    output logic                 Capture,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [PC_W-1:0]      pattern_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CAPTURE,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CL_W-1:0] bit_cnt;
    logic [CL_W-1:0] last_bit;
    logic [PC_W-1:0] pattern_cnt;
    logic            pass_q;
    logic            last_shift;
    logic            all_captured;

    // A chain length of zero is run as a single-cycle shift phase.
    assign last_bit     = (Chain_Length == '0) ? '0 : Chain_Length - CL_W'(1);
    assign last_shift   = (bit_cnt == last_bit);
    assign all_captured = (pattern_cnt == Pattern_Count);
    assign pattern_idx  = pattern_cnt;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection and output decode; outputs depend only on registers.
    always_comb begin
        state_nxt   = state;
        internalRst = 1'b0;
        PRPG_En     = 1'b0;
        MISR_En     = 1'b0;
        Scan_En     = 1'b0;
        Capture     = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        pass        = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_INIT;
            end
            S_INIT: begin
                internalRst = 1'b1;
                busy        = 1'b1;
                state_nxt   = S_SHIFT;
            end
            S_SHIFT: begin
                Scan_En = 1'b1;
                PRPG_En = 1'b1;
                busy    = 1'b1;
                // First load holds unknown chain contents; keep them out of the MISR.
                MISR_En = (pattern_cnt != '0);
                if (last_shift) begin
                    state_nxt = all_captured ? S_COMPARE : S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                Capture   = 1'b1;
                busy      = 1'b1;
                state_nxt = S_SHIFT;
            end
            S_COMPARE: begin
                busy      = 1'b1;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                pass = pass_q;
                if (start) state_nxt = S_INIT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) state_nxt = S_IDLE;
    end

    // Shift-bit counter, capture counter and the registered compare result.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            bit_cnt     <= '0;
            pattern_cnt <= '0;
            pass_q      <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    bit_cnt     <= '0;
                    pattern_cnt <= '0;
                    pass_q      <= 1'b0;
                end
                S_SHIFT: begin
                    if (last_shift) begin
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CL_W'(1);
                    end
                end
                S_CAPTURE: begin
                    pattern_cnt <= pattern_cnt + PC_W'(1);
                end
                S_COMPARE: begin
                    pass_q <= (MISR_Sig == Golden_Sig);
                end
                default: begin
                    bit_cnt <= bit_cnt;
                end
            endcase
        end
    end

endmodule
